// File: rtl/demux_1to2.sv
// rtl/demux_1to2.sv - 1-to-2 data/valid demultiplexer, combinational or output-registered
module demux_1to2 #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b0
) (
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    input  logic [WIDTH-1:0] a,
    input  logic             sel,
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             y_valid,
    output logic             z_valid
);

    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] z_d;
    logic             y_valid_d;
    logic             z_valid_d;

    // Steer the word and its qualifier; the unselected branch is driven to zero, and valid never gates data
    always_comb begin
        y_d       = '0;
        z_d       = '0;
        y_valid_d = 1'b0;
        z_valid_d = 1'b0;
        if (sel) begin
            z_d       = a;
            z_valid_d = in_valid;
        end else begin
            y_d       = a;
            y_valid_d = in_valid;
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] y_q;
            logic [WIDTH-1:0] z_q;
            logic             y_valid_q;
            logic             z_valid_q;

            // One-stage output register; reset clears any in-flight word immediately
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    y_q       <= '0;
                    z_q       <= '0;
                    y_valid_q <= 1'b0;
                    z_valid_q <= 1'b0;
                end else begin
                    y_q       <= y_d;
                    z_q       <= z_d;
                    y_valid_q <= y_valid_d;
                    z_valid_q <= z_valid_d;
                end
            end

            assign y       = y_q;
            assign z       = z_q;
            assign y_valid = y_valid_q;
            assign z_valid = z_valid_q;
        end else begin : g_comb
            // The clock has no role on the purely combinational path
            logic unused_clk;
            assign unused_clk = clk;

            // Zero-latency routing, forced to zero while reset is held
            always_comb begin
                y       = y_d;
                z       = z_d;
                y_valid = y_valid_d;
                z_valid = z_valid_d;
                if (rst) begin
                    y       = '0;
                    z       = '0;
                    y_valid = 1'b0;
                    z_valid = 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_demux_1to2.sv
// tb/tb_demux_1to2.sv - self-checking bench for demux_1to2 (combinational and registered builds)
module tb_demux_1to2;

    logic       clk;
    logic       rst;
    logic       sel;
    logic       in_valid;
    logic       a1;
    logic [7:0] a8;

    logic       y1, z1, yv1, zv1;
    logic [7:0] y8c, z8c;
    logic       yv8c, zv8c;
    logic [7:0] y8r, z8r;
    logic       yv8r, zv8r;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_ry, exp_rz;
    logic       exp_ryv, exp_rzv;

    demux_1to2 #(.WIDTH(1), .REG_OUT(1'b0)) u1 (
        .y(y1), .z(z1), .a(a1), .sel(sel), .clk(clk), .rst(rst),
        .in_valid(in_valid), .y_valid(yv1), .z_valid(zv1)
    );

    demux_1to2 #(.WIDTH(8), .REG_OUT(1'b0)) u8c (
        .y(y8c), .z(z8c), .a(a8), .sel(sel), .clk(clk), .rst(rst),
        .in_valid(in_valid), .y_valid(yv8c), .z_valid(zv8c)
    );

    demux_1to2 #(.WIDTH(8), .REG_OUT(1'b1)) u8r (
        .y(y8r), .z(z8r), .a(a8), .sel(sel), .clk(clk), .rst(rst),
        .in_valid(in_valid), .y_valid(yv8r), .z_valid(zv8r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] ey, ez;
        logic       eyv, ezv;

        rst = 1'b1; a1 = 1'b1; a8 = 8'hFF; sel = 1'b0; in_valid = 1'b1;
        #3;
        chk("rst_u1_y", {7'd0, y1}, 8'h00);
        chk("rst_u1_z", {7'd0, z1}, 8'h00);
        chk("rst_u1_yv", {7'd0, yv1}, 8'h00);
        chk("rst_u1_zv", {7'd0, zv1}, 8'h00);
        chk("rst_u8c_y", y8c, 8'h00);
        chk("rst_u8c_z", z8c, 8'h00);
        chk("rst_u8c_yv", {7'd0, yv8c}, 8'h00);
        chk("rst_u8c_zv", {7'd0, zv8c}, 8'h00);
        chk("rst_u8r_y", y8r, 8'h00);
        chk("rst_u8r_z", z8r, 8'h00);
        chk("rst_u8r_yv", {7'd0, yv8r}, 8'h00);
        chk("rst_u8r_zv", {7'd0, zv8r}, 8'h00);

        @(posedge clk); #2;
        rst = 1'b0;

        // WIDTH=1 truth table
        a1 = 1'b0; sel = 1'b0; #5;
        chk("tt00_y", {7'd0, y1}, 8'h00); chk("tt00_z", {7'd0, z1}, 8'h00);
        a1 = 1'b1; sel = 1'b0; #5;
        chk("tt10_y", {7'd0, y1}, 8'h01); chk("tt10_z", {7'd0, z1}, 8'h00);
        a1 = 1'b0; sel = 1'b1; #5;
        chk("tt01_y", {7'd0, y1}, 8'h00); chk("tt01_z", {7'd0, z1}, 8'h00);
        a1 = 1'b1; sel = 1'b1; #5;
        chk("tt11_y", {7'd0, y1}, 8'h00); chk("tt11_z", {7'd0, z1}, 8'h01);

        // valid routing
        in_valid = 1'b1; sel = 1'b0; #5;
        chk("v_s0_yv", {7'd0, yv1}, 8'h01); chk("v_s0_zv", {7'd0, zv1}, 8'h00);
        sel = 1'b1; #5;
        chk("v_s1_yv", {7'd0, yv1}, 8'h00); chk("v_s1_zv", {7'd0, zv1}, 8'h01);
        in_valid = 1'b0; a1 = 1'b1; #5;
        chk("v_off_yv", {7'd0, yv1}, 8'h00); chk("v_off_zv", {7'd0, zv1}, 8'h00);
        chk("v_off_z", {7'd0, z1}, 8'h01);

        // WIDTH=8 combinational
        a8 = 8'hA5; sel = 1'b0; #5;
        chk("w8_s0_y", y8c, 8'hA5); chk("w8_s0_z", z8c, 8'h00);
        sel = 1'b1; #5;
        chk("w8_s1_y", y8c, 8'h00); chk("w8_s1_z", z8c, 8'hA5);

        // registered latency
        @(posedge clk); #2;
        a8 = 8'h00; sel = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("r_idle_y", y8r, 8'h00); chk("r_idle_z", z8r, 8'h00);
        #1;
        a8 = 8'h3C; sel = 1'b1; in_valid = 1'b1;
        #1;
        chk("r_pre_z", z8r, 8'h00); chk("r_pre_zv", {7'd0, zv8r}, 8'h00);
        @(posedge clk); #1;
        chk("r_n_z", z8r, 8'h3C); chk("r_n_zv", {7'd0, zv8r}, 8'h01);
        chk("r_n_y", y8r, 8'h00);
        #2;
        sel = 1'b0;
        #1;
        chk("r_hold_z", z8r, 8'h3C);
        @(posedge clk); #1;
        chk("r_n1_y", y8r, 8'h3C); chk("r_n1_z", z8r, 8'h00);
        chk("r_n1_yv", {7'd0, yv8r}, 8'h01); chk("r_n1_zv", {7'd0, zv8r}, 8'h00);

        // asynchronous reset between edges
        a1 = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_u1_y", {7'd0, y1}, 8'h00);
        chk("ar_u8c_y", y8c, 8'h00);
        chk("ar_u8r_y", y8r, 8'h00);
        chk("ar_u8r_yv", {7'd0, yv8r}, 8'h00);
        #2;
        rst = 1'b0;
        #1;
        chk("rel_u1_y", {7'd0, y1}, 8'h01);
        chk("rel_u8c_y", y8c, 8'h3C);
        chk("rel_u8r_y_wait", y8r, 8'h00);
        @(posedge clk); #1;
        chk("rel_u8r_y", y8r, 8'h3C);
        chk("rel_u8r_yv", {7'd0, yv8r}, 8'h01);

        exp_ry = 8'h3C; exp_rz = 8'h00; exp_ryv = 1'b1; exp_rzv = 1'b0;

        // random regression
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #2;
            a1       = 1'($urandom);
            a8       = 8'($urandom);
            sel      = 1'($urandom);
            in_valid = 1'($urandom);
            rst      = ($urandom_range(0, 15) == 0);
            #1;
            ey  = rst ? 8'h00 : (sel ? 8'h00 : a8);
            ez  = rst ? 8'h00 : (sel ? a8 : 8'h00);
            eyv = !rst && in_valid && !sel;
            ezv = !rst && in_valid && sel;
            chk("rnd_c_y", y8c, ey);
            chk("rnd_c_z", z8c, ez);
            chk("rnd_c_yv", {7'd0, yv8c}, {7'd0, eyv});
            chk("rnd_c_zv", {7'd0, zv8c}, {7'd0, ezv});
            chk("rnd_c1_y", {7'd0, y1}, {7'd0, !rst && !sel && a1});
            chk("rnd_c1_z", {7'd0, z1}, {7'd0, !rst && sel && a1});
            if (rst) begin
                exp_ry = 8'h00; exp_rz = 8'h00; exp_ryv = 1'b0; exp_rzv = 1'b0;
            end
            chk("rnd_r_pre_y", y8r, exp_ry);
            chk("rnd_r_pre_z", z8r, exp_rz);
            @(posedge clk); #1;
            exp_ry  = ey;
            exp_rz  = ez;
            exp_ryv = eyv;
            exp_rzv = ezv;
            chk("rnd_r_y", y8r, exp_ry);
            chk("rnd_r_z", z8r, exp_rz);
            chk("rnd_r_yv", {7'd0, yv8r}, {7'd0, exp_ryv});
            chk("rnd_r_zv", {7'd0, zv8r}, {7'd0, exp_rzv});
            chk("rnd_excl_c", {7'd0, (y8c != 8'h00) && (z8c != 8'h00)}, 8'h00);
            chk("rnd_excl_r", {7'd0, (y8r != 8'h00) && (z8r != 8'h00)}, 8'h00);
            chk("rnd_excl_v", {7'd0, yv8r && zv8r}, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
